// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick generator: default widths, reset divisor and
// named divisors for the game-logic rates derived from the 40 MHz pixel clock.
package tick_gen_pkg;

   localparam int CNT_W_DEF     = 24;
   localparam int RESET_DIV_DEF = 666667;

   // Rates from a 40 MHz clock. DIV_1HZ does not fit in 24 bits; use CNT_W >= 26 for it.
   localparam int DIV_60HZ = 666667;
   localparam int DIV_30HZ = 1333333;
   localparam int DIV_10HZ = 4000000;
   localparam int DIV_1HZ  = 40000000;

   function automatic int calc_ch_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/tick_chan.sv
// One divider channel: free-running counter with an active and a pending divisor,
// producing a registered one-cycle tick and a square wave that toggles per tick.
module tick_chan
   import tick_gen_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int RESET_DIV = RESET_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             restart,
   input  logic             we,
   input  logic [CNT_W-1:0] wdiv,
   output logic             tick,
   output logic             sq
);

   localparam logic [CNT_W-1:0] RST_DIV = (RESET_DIV == 0) ? CNT_W'(1) : CNT_W'(RESET_DIV);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_act;
   logic [CNT_W-1:0] div_sh;
   logic [CNT_W-1:0] wdiv_n;
   logic             wrap;

   assign wdiv_n = (wdiv == '0) ? CNT_W'(1) : wdiv;
   // >= rather than ==: a divisor shrunk while frozen below the held count must still wrap.
   assign wrap   = (cnt >= div_act - CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         div_act <= RST_DIV;
         div_sh  <= RST_DIV;
         tick    <= 1'b0;
         sq      <= 1'b0;
      end else if (restart) begin
         cnt     <= '0;
         tick    <= 1'b0;
         sq      <= 1'b0;
         div_act <= we ? wdiv_n : div_sh;
         if (we) div_sh <= wdiv_n;
      end else if (en) begin
         if (we) div_sh <= wdiv_n;
         if (wrap) begin
            cnt     <= '0;
            tick    <= 1'b1;
            sq      <= ~sq;
            div_act <= we ? wdiv_n : div_sh;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
         if (we) begin
            div_sh  <= wdiv_n;
            div_act <= wdiv_n;
         end
      end
   end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: decodes divisor writes to per-channel strobes
// and fans the restart strobe out to every channel.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int RESET_DIV = RESET_DIV_DEF,
   parameter int CH_W      = calc_ch_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              restart,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq
);

   logic [NUM_CH-1:0] we_vec;

   // An out-of-range cfg_ch matches no channel, so the write is dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign we_vec[i] = cfg_we && (cfg_ch == CH_W'(i));

      tick_chan #(
         .CNT_W     (CNT_W),
         .RESET_DIV (RESET_DIV)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (ch_en[i]),
         .restart (restart),
         .we      (we_vec[i]),
         .wdiv    (cfg_div),
         .tick    (tick[i]),
         .sq      (sq[i])
      );
   end

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: period-level reference model compared every cycle,
// plus directed sequences with hand-computed tick positions.
module tb_tick_gen;

   localparam int NUM_CH    = 3;
   localparam int CNT_W     = 8;
   localparam int RESET_DIV = 5;
   localparam int CH_W      = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NUM_CH-1:0] ch_en = '1;
   logic              restart = 1'b0;
   logic              cfg_we = 1'b0;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [CNT_W-1:0]  cfg_div = '0;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;

   int n_checks = 0;
   int n_errors = 0;

   tick_gen #(
      .NUM_CH    (NUM_CH),
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV),
      .CH_W      (CH_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ch_en   (ch_en),
      .restart (restart),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_div (cfg_div),
      .tick    (tick),
      .sq      (sq)
   );

   always #5 clk = ~clk;

   // Reference model: per channel, enabled cycles elapsed in the current period,
   // the period length in force, and the length queued for the next period.
   int elapsed [NUM_CH];
   int period  [NUM_CH];
   int pending [NUM_CH];
   bit m_tick  [NUM_CH];
   bit m_sq    [NUM_CH];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            elapsed[i] = 0;
            period[i]  = RESET_DIV;
            pending[i] = RESET_DIV;
            m_tick[i]  = 0;
            m_sq[i]    = 0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            int d;
            bit w;
            d = (cfg_div == 0) ? 1 : int'(cfg_div);
            w = cfg_we && (int'(cfg_ch) == i);
            if (restart) begin
               elapsed[i] = 0;
               m_tick[i]  = 0;
               m_sq[i]    = 0;
               if (w) pending[i] = d;
               period[i] = pending[i];
            end else if (ch_en[i]) begin
               if (w) pending[i] = d;
               if (elapsed[i] + 1 >= period[i]) begin
                  elapsed[i] = 0;
                  m_tick[i]  = 1;
                  m_sq[i]    = !m_sq[i];
                  period[i]  = pending[i];
               end else begin
                  elapsed[i] = elapsed[i] + 1;
                  m_tick[i]  = 0;
               end
            end else begin
               m_tick[i] = 0;
               if (w) begin
                  pending[i] = d;
                  period[i]  = d;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [NUM_CH-1:0] et, es;
      for (int i = 0; i < NUM_CH; i++) begin
         et[i] = m_tick[i];
         es[i] = m_sq[i];
      end
      n_checks++;
      if (tick !== et || sq !== es) begin
         n_errors++;
         $display("FAIL model_cmp t=%0t tick=%b exp=%b sq=%b exp=%b", $time, tick, et, sq, es);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // Reset with RESET_DIV=5: ticks after edges 5, 10, 15.
      repeat (3) @(negedge clk);
      chk("reset_tick", 32'(tick), 32'd0);
      chk("reset_sq", 32'(sq), 32'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         chk("rst_tick0", 32'(tick[0]), 32'((k % 5) == 0));
         chk("rst_sq0", 32'(sq[0]), 32'((k >= 5 && k < 10) || k >= 15));
      end

      // Ch0 div=4 loaded via restart, then write 7 while cnt=1.
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4; restart = 1'b1;
      step();
      cfg_we = 1'b0; restart = 1'b0;
      step();
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7;
      step();
      cfg_we = 1'b0;
      for (int k = 3; k <= 20; k++) begin
         if (k == 20) begin
            cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
         end
         step();
         cfg_we = 1'b0;
         chk("div4to7_tick0", 32'(tick[0]), 32'(k == 4 || k == 11 || k == 18));
      end
      // Divisor 0 acts as 1 from the wrap at edge 25 onward.
      for (int k = 21; k <= 30; k++) begin
         step();
         chk("div0_tick0", 32'(tick[0]), 32'(k >= 25));
      end

      // Write to out-of-range channel index 3 is dropped.
      cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd2;
      step();
      cfg_we = 1'b0;
      repeat (12) step();

      // Randomised traffic with a mid-period asynchronous reset.
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NUM_CH; i++) ch_en[i] = ($urandom_range(0, 9) < 8);
         cfg_we  = ($urandom_range(0, 99) < 15);
         cfg_ch  = CH_W'($urandom_range(0, 3));
         cfg_div = CNT_W'($urandom_range(0, 9));
         restart = ($urandom_range(0, 99) < 3);
         if (c == 400) begin
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst_tick", 32'(tick), 32'd0);
            chk("async_rst_sq", 32'(sq), 32'd0);
            step();
            rst_n = 1'b1;
         end
         step();
      end
      cfg_we = 1'b0; restart = 1'b0; ch_en = '1;
      repeat (5) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
